// File: rtl/pulse_sched_pkg.sv
// Shared types and default sizing for the pulse serializer controller.
package pulse_sched_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int REP_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_shifter.sv
// PAT_W-bit load/shift register; shifts left with zero fill, MSB is the serial bit.
module pulse_shifter #(
    parameter int PAT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic             SHIFT,
    input  logic [PAT_W-1:0] DIN,
    output logic             MSB
);

    logic [PAT_W-1:0] r_sr;
    logic [PAT_W-1:0] w_shifted;

    assign w_shifted[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
            assign w_shifted[gi] = r_sr[gi-1];
        end
    endgenerate

    // Load wins over shift so a pattern reload is seamless on the last bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sr <= '0;
        end else if (LOAD) begin
            r_sr <= DIN;
        end else if (SHIFT) begin
            r_sr <= w_shifted;
        end
    end

    assign MSB = r_sr[PAT_W-1];

endmodule

// File: rtl/pulse_train_arbiter.sv
// Round-robin arbiter for two pattern producers feeding one MSB-first pulse serializer.
module pulse_train_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [PAT_W-1:0] PAT0,
    input  logic [PAT_W-1:0] PAT1,
    input  logic [REP_W-1:0] REP0,
    input  logic [REP_W-1:0] REP1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             BUSY,
    output logic             OWNER,
    output logic             Q
);

    localparam int CNT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [REP_W-1:0]   r_rep_cnt;
    logic [PAT_W-1:0]   r_hold;
    logic               r_owner;
    logic               r_last;
    logic               r_ack0;
    logic               r_ack1;

    logic               w_any_req;
    logic               w_win_idx;
    logic [PAT_W-1:0]   w_win_pat;
    logic [REP_W-1:0]   w_win_rep;
    logic               w_load;
    logic               w_shift;
    logic [PAT_W-1:0]   w_din;
    logic               w_msb;

    // On a tie the requester that was not served last wins.
    assign w_any_req = REQ0 | REQ1;
    assign w_win_idx = (REQ0 & REQ1) ? ~r_last : REQ1;
    assign w_win_pat = w_win_idx ? PAT1 : PAT0;
    assign w_win_rep = w_win_idx ? REP1 : REP0;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_din        = w_win_pat;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_load       = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bit_cnt != LAST_BIT) begin
                    w_shift = 1'b1;
                end else if (r_rep_cnt != '0) begin
                    w_load = 1'b1;
                    w_din  = r_hold;
                end else begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_hold    <= '0;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            if (r_state == IDLE && w_any_req) begin
                r_hold    <= w_win_pat;
                r_rep_cnt <= w_win_rep;
                r_bit_cnt <= '0;
                r_owner   <= w_win_idx;
                r_last    <= w_win_idx;
                r_ack0    <= ~w_win_idx;
                r_ack1    <= w_win_idx;
            end else if (r_state == SHIFT) begin
                if (r_bit_cnt != LAST_BIT) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end else if (r_rep_cnt != '0) begin
                    r_rep_cnt <= r_rep_cnt - 1'b1;
                    r_bit_cnt <= '0;
                end
            end
        end
    end

    pulse_shifter #(
        .PAT_W (PAT_W)
    ) u_shifter (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (w_load),
        .SHIFT (w_shift),
        .DIN   (w_din),
        .MSB   (w_msb)
    );

    assign Q     = (r_state == SHIFT) & w_msb;
    assign BUSY  = (r_state != IDLE);
    assign OWNER = r_owner;
    assign ACK0  = r_ack0;
    assign ACK1  = r_ack1;
    assign DONE0 = (r_state == DONE) & ~r_owner;
    assign DONE1 = (r_state == DONE) &  r_owner;

endmodule

// File: doc/pulse_train_arbiter.md
# pulse_train_arbiter

Two-requester controller for the shared 8-bit pulse serializer. It arbitrates round-robin between requesters and loads the winner's pattern into the serializer. It then shifts the pattern out MSB-first on a single pulse line, repeating it a requested number of times, and reports acceptance and completion per requester. It sits between pattern producers and the single physical pulse output `Q`.

## Interface
Parameters:
- `PAT_W`, 8: pattern width in bits, one bit emitted per cycle.
- `REP_W`, 2: width of the repeat field; the pattern is emitted REP+1 times.

Ports:
- `CLK` input 1: single clock; all state changes on the rising edge.
- `RST` input 1: synchronous, active-high reset, sampled on `CLK` rising edge.
- `REQ0`, `REQ1` input 1: request from requester 0/1, level-sensitive.
- `PAT0`, `PAT1` input PAT_W: pattern, held stable while the matching REQ is high and ACK has not yet been seen.
- `REP0`, `REP1` input REP_W: repeat count, with the same stability rule as the pattern.
- `ACK0`, `ACK1` output 1: one-cycle pulse; the request was captured.
- `DONE0`, `DONE1` output 1: one-cycle pulse; the granted transfer has finished.
- `BUSY` output 1: high from the ACK cycle through the DONE cycle inclusive.
- `OWNER` output 1: index of the current or last-granted requester.
- `Q` output 1: serialized pulse output.

## Operation
- States are IDLE, SHIFT and DONE.
- RST forces the following, all registered:
  - state IDLE, shift register 0, bit counter 0, repeat counter 0.
  - `Q`=0, `ACK*`=0, `DONE*`=0, `BUSY`=0, `OWNER`=0.
  - last-served pointer `LAST`=1, so requester 0 wins the first tie.
- IDLE behaviour:
  - Each edge samples REQ0/REQ1.
  - If exactly one is high, that requester wins.
  - If both are high, the requester ≠ `LAST` wins.
  - On a win: capture PAT into the shift register and into a hold register, load the repeat counter with REP, clear the bit counter, set `OWNER` and `LAST` to the winner, pulse ACK for the winner, and go to SHIFT.
  - If no request is high, stay in IDLE with no output change.
- SHIFT behaviour:
  - `Q` = shift register MSB.
  - Each edge: if bit counter < PAT_W-1, shift left with 0 fill and increment the bit counter.
  - If bit counter = PAT_W-1 and repeat counter ≠ 0: reload from the hold register, decrement the repeat counter, clear the bit counter. Output is seamless, with no gap cycle.
  - If bit counter = PAT_W-1 and repeat counter = 0: go to DONE.
- DONE behaviour: `Q`=0, DONE pulses for the owner, and the next edge returns to IDLE.
- REQ and PAT inputs are ignored outside IDLE.
- A REQ still high when IDLE is re-entered counts as a new request.
- `Q`=0 in IDLE and DONE.
- Reset during SHIFT or DONE aborts the transfer: no DONE pulse is issued, and `Q` is 0 from the cycle after the reset edge.
- Counter widths: the bit counter is clog2(PAT_W) bits, the repeat counter is REP_W bits; no wrap beyond those ranges.

## Timing
- Request high before edge E0 (FSM in IDLE):
  - After E0: ACK=1, BUSY=1, `Q`=PAT[PAT_W-1].
  - After E1: ACK=0.
  - After E(k), k=0..PAT_W-1: `Q`=PAT[PAT_W-1-k]; the sequence repeats for each of the REP+1 passes.
  - After E(PAT_W·(REP+1)): DONE=1, `Q`=0.
  - One edge later: IDLE, BUSY=0.
- Latency:
  - First bit appears 1 cycle after the request is sampled.
  - DONE occurs PAT_W·(REP+1) cycles after ACK.
- Minimum gap between back-to-back transfers is 2 cycles of `Q`=0 (the DONE cycle plus the IDLE cycle).
- REQ dropped before the sampling edge means no grant. No request is queued during BUSY.

## Structure
- Shared package `pulse_sched_pkg`:
  - state enum {IDLE, SHIFT, DONE}.
  - default constants `PAT_W_DEF`=8, `REP_W_DEF`=2.
- Sub-module `pulse_shifter`: a PAT_W-bit load/shift register with `LOAD`, `SHIFT`, `DIN` and `MSB` ports, in the same role as the existing pulse generator's shifter.
- The top module contains the FSM, arbiter, counters and hold register.

## Test plan
- Reset then idle: RST for 2 cycles, no REQ → `Q`=0, BUSY=0, ACK/DONE=0 for 20 cycles.
- Single request: REQ0, PAT0=0xF0, REP0=0 → ACK0 after E0; `Q`=1,1,1,1,0,0,0,0 over E0..E7; DONE0 after E8; BUSY low after E9.
- Repeat: REQ1, PAT1=0xA5, REP1=2 → `Q` shows 0xA5 three times with no gap (24 cycles); DONE1 asserted 24 cycles after ACK1.
- Tie and round-robin:
  - Both REQ held high with PAT0=0x81, PAT1=0x7E → grant order 0, 1, 0; `OWNER` toggles accordingly.
  - Each grant is preceded by 2 idle `Q`=0 cycles.
- Mid-transfer reset: RST asserted at bit 3 of 0xFF → `Q`=0 from the next cycle, no DONE0, `LAST`=1. A subsequent tie is granted to requester 0.
- Request withdrawal: REQ0 pulsed low before the sampling edge while busy with requester 1 → no ACK0, no grant once IDLE is reached.
